// File: rtl/fetch2_bundle_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch2_bundle_queue
// Description : Fetch-stage-2 bundle handling.
//               - Picks the lowest-index taken control transfer in the bundle
//                 and truncates the bundle after it.
//               - Raises a fetch redirect when the BTB missed on that slot.
//               - Buffers truncated bundles in a DEPTH-entry FIFO with
//                 valid/ready handshakes on both sides.
// Ports       : clk, reset (async, active-low), flush_i
//               input side : in_valid_i, in_ready_o, pc_i, bundle_i,
//                            is_ctrl_i, ctrl_type_i, pred_i, btb_hit_i,
//                            target_i, ras_addr_i
//               redirect   : redirect_o, redirect_pc_o, redirect_rtr_o,
//                            redirect_call_o, call_pc_o
//               output side: out_valid_o, out_ready_i, out_pc_o,
//                            out_bundle_o, out_mask_o, out_target_o,
//                            out_pred_o, count_o
// Revision    : 1.0 - initial release
// ============================================================================
module fetch2_bundle_queue #(
  parameter int FETCH_WIDTH = 4,
  parameter int INST_W      = 64,
  parameter int PC_W        = 32,
  parameter int INST_BYTES  = 8,
  parameter int DEPTH       = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic [PC_W-1:0]               pc_i,
  input  logic [FETCH_WIDTH*INST_W-1:0] bundle_i,
  input  logic [FETCH_WIDTH-1:0]        is_ctrl_i,
  input  logic [2*FETCH_WIDTH-1:0]      ctrl_type_i,
  input  logic [FETCH_WIDTH-1:0]        pred_i,
  input  logic [FETCH_WIDTH-1:0]        btb_hit_i,
  input  logic [FETCH_WIDTH*PC_W-1:0]   target_i,
  input  logic [PC_W-1:0]               ras_addr_i,
  output logic                          redirect_o,
  output logic [PC_W-1:0]               redirect_pc_o,
  output logic                          redirect_rtr_o,
  output logic                          redirect_call_o,
  output logic [PC_W-1:0]               call_pc_o,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [PC_W-1:0]               out_pc_o,
  output logic [FETCH_WIDTH*INST_W-1:0] out_bundle_o,
  output logic [FETCH_WIDTH-1:0]        out_mask_o,
  output logic [FETCH_WIDTH*PC_W-1:0]   out_target_o,
  output logic [FETCH_WIDTH-1:0]        out_pred_o,
  output logic [$clog2(DEPTH):0]        count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] C_TYPE_RET  = 2'b00;
  localparam logic [1:0] C_TYPE_CALL = 2'b01;
  localparam logic [1:0] C_TYPE_COND = 2'b11;

  // --------------------------------------------------------------------------
  // Slot selection and truncation
  // --------------------------------------------------------------------------
  logic [FETCH_WIDTH-1:0]      wTaken;
  logic [FETCH_WIDTH-1:0]      wSelOh;
  logic                        wSelFound;
  logic [FETCH_WIDTH-1:0]      wMask;
  logic [PC_W-1:0]             wSlotPc [FETCH_WIDTH];
  logic [FETCH_WIDTH*PC_W-1:0] wFinalTgt;

  logic [1:0]      wSelType;
  logic            wSelHit;
  logic [PC_W-1:0] wSelPc;
  logic [PC_W-1:0] wSelTgt;

  // Conditional branches are taken only when predicted; every other control
  // transfer is unconditionally taken.
  for (genvar i = 0; i < FETCH_WIDTH; i++) begin : g_slot
    assign wTaken[i]  = is_ctrl_i[i] & (pred_i[i] | (ctrl_type_i[2*i +: 2] != C_TYPE_COND));
    assign wSlotPc[i] = pc_i + PC_W'(i * INST_BYTES);
    // A selected return that missed the BTB takes its target from the RAS.
    assign wFinalTgt[i*PC_W +: PC_W] =
      (wSelOh[i] && (ctrl_type_i[2*i +: 2] == C_TYPE_RET) && !btb_hit_i[i])
        ? ras_addr_i : target_i[i*PC_W +: PC_W];
  end

  // Isolate the lowest set bit: x & -x.
  assign wSelOh    = wTaken & (~wTaken + FETCH_WIDTH'(1));
  assign wSelFound = |wTaken;
  // Ones in slots 0..sel: the one-hot bit plus every bit below it.
  assign wMask     = wSelFound ? (wSelOh | (wSelOh - FETCH_WIDTH'(1))) : '1;

  always_comb begin
    wSelType = '0;
    wSelHit  = 1'b0;
    wSelPc   = '0;
    wSelTgt  = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (wSelOh[i]) begin
        wSelType = ctrl_type_i[2*i +: 2];
        wSelHit  = btb_hit_i[i];
        wSelPc   = wSlotPc[i];
        wSelTgt  = wFinalTgt[i*PC_W +: PC_W];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Handshake and redirect
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] rCount;
  logic [PTR_W-1:0] rWrPtr;
  logic [PTR_W-1:0] rRdPtr;
  logic             wAcc;
  logic             wDeq;
  logic             wRedir;

  // in_ready depends only on occupancy, never on out_ready_i.
  assign in_ready_o  = (rCount < CNT_W'(DEPTH));
  assign out_valid_o = (rCount != '0);
  assign wAcc        = in_valid_i & in_ready_o & ~flush_i;
  assign wDeq        = out_valid_o & out_ready_i & ~flush_i;

  // Gated by reset so the combinational redirect stays quiet during reset.
  assign wRedir          = reset & wAcc & wSelFound & ~wSelHit;
  assign redirect_o      = wRedir;
  assign redirect_pc_o   = wRedir ? wSelTgt : '0;
  assign redirect_rtr_o  = wRedir & (wSelType == C_TYPE_RET);
  assign redirect_call_o = wRedir & (wSelType == C_TYPE_CALL);
  assign call_pc_o       = wRedir ? wSelPc : '0;

  // --------------------------------------------------------------------------
  // Bundle FIFO
  // --------------------------------------------------------------------------
  logic [PC_W-1:0]               rPcMem     [DEPTH];
  logic [FETCH_WIDTH*INST_W-1:0] rBundleMem [DEPTH];
  logic [FETCH_WIDTH-1:0]        rMaskMem   [DEPTH];
  logic [FETCH_WIDTH*PC_W-1:0]   rTgtMem    [DEPTH];
  logic [FETCH_WIDTH-1:0]        rPredMem   [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rCount <= '0;
      rWrPtr <= '0;
      rRdPtr <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        rPcMem[e]     <= '0;
        rBundleMem[e] <= '0;
        rMaskMem[e]   <= '0;
        rTgtMem[e]    <= '0;
        rPredMem[e]   <= '0;
      end
    end else if (flush_i) begin
      rCount <= '0;
      rWrPtr <= '0;
      rRdPtr <= '0;
    end else begin
      if (wAcc) begin
        rPcMem[rWrPtr]     <= pc_i;
        rBundleMem[rWrPtr] <= bundle_i;
        rMaskMem[rWrPtr]   <= wMask;
        rTgtMem[rWrPtr]    <= wFinalTgt;
        rPredMem[rWrPtr]   <= pred_i;
        rWrPtr             <= rWrPtr + PTR_W'(1);
      end
      if (wDeq) begin
        rRdPtr <= rRdPtr + PTR_W'(1);
      end
      rCount <= rCount + CNT_W'(wAcc) - CNT_W'(wDeq);
    end
  end

  assign out_pc_o     = rPcMem[rRdPtr];
  assign out_bundle_o = rBundleMem[rRdPtr];
  assign out_mask_o   = rMaskMem[rRdPtr];
  assign out_target_o = rTgtMem[rRdPtr];
  assign out_pred_o   = rPredMem[rRdPtr];
  assign count_o      = rCount;

endmodule
`default_nettype wire
